// File: rtl/counter_modulo_ud.sv
// Up/down modulo counter, 0..MAX_VALUE, with wrap or one-shot stop, clear,
// saturating load and a combinational terminal-count pulse.
module counter_modulo_ud #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state
);

  if (MAX_VALUE < 1 || longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("MAX_VALUE out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StHold  = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             done_q;

  logic             at_term;
  logic             active;
  logic [WIDTH-1:0] load_sat;

  always_comb begin
    at_term  = up ? (count_q == MaxVal) : (count_q == '0);
    active   = (state_q == StHold) || (state_q == StRun);
    load_sat = (load_val > MaxVal) ? MaxVal : load_val;
    tc       = en & at_term & active & ~clr & ~load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      state_q <= StReset;
      done_q  <= 1'b0;
    end else if (state_q == StReset) begin
      // First edge after reset only arms the counter; all controls ignored.
      state_q <= StHold;
    end else if (clr) begin
      count_q <= '0;
      done_q  <= 1'b0;
      state_q <= StHold;
    end else if (load) begin
      count_q <= load_sat;
      done_q  <= 1'b0;
      state_q <= en ? StRun : StHold;
    end else if (state_q != StDone) begin
      state_q <= en ? StRun : StHold;
      if (en) begin
        if (!at_term) begin
          count_q <= up ? count_q + 1'b1 : count_q - 1'b1;
        end else if (oneshot) begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end else begin
          // Explicit wrap avoids relying on modular overflow.
          count_q <= up ? '0 : MaxVal;
        end
      end
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_modulo_ud.sv
// Directed self-checking bench for counter_modulo_ud (WIDTH=8, MAX_VALUE=9).
module tb_counter_modulo_ud;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, load, en, up, oneshot;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc, done;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  counter_modulo_ud #(.WIDTH(8), .MAX_VALUE(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .oneshot  (oneshot),
    .count    (count),
    .tc       (tc),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] c, input logic [31:0] s,
                         input logic [31:0] t, input logic [31:0] d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".state"}, 32'(state), s);
    chk({tag, ".tc"}, 32'(tc), t);
    chk({tag, ".done"}, 32'(done), d);
  endtask

  initial begin
    // 1. Reset
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'd0;
    up = 1'b1; oneshot = 1'b0;
    #2;
    chk_all("rst_async", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    step(1);
    chk_all("rst_first_edge", 0, 1, 0, 0);
    step(1);
    chk_all("rst_second_edge", 1, 2, 0, 0);

    // 2. Up wrap
    clr = 1'b1;
    step(1);
    chk_all("clr_to_zero", 0, 1, 0, 0);
    clr = 1'b0;
    step(9);
    chk_all("up_at_9", 9, 2, 1, 0);
    step(1);
    chk_all("up_wrap", 0, 2, 0, 0);
    en = 1'b0;
    step(4);
    chk_all("hold_en0", 0, 1, 0, 0);

    // 3. Down wrap
    load_val = 8'd2; load = 1'b1; en = 1'b1; up = 1'b0;
    #1 chk("tc_masked_by_load", 32'(tc), 0);
    step(1);
    load = 1'b0;
    chk_all("load_2", 2, 2, 0, 0);
    step(1);
    chk("down_1", 32'(count), 1);
    step(1);
    chk_all("down_0", 0, 2, 1, 0);
    step(1);
    chk_all("down_wrap_9", 9, 2, 0, 0);
    step(1);
    chk("down_8", 32'(count), 8);
    up = 1'b1;
    #1 chk("tc_dir_8", 32'(tc), 0);
    step(1);
    chk_all("dir_up_9", 9, 2, 1, 0);
    up = 1'b0;
    #1 chk("tc_dir_flip", 32'(tc), 0);
    up = 1'b1;

    // 4. One-shot
    clr = 1'b1;
    step(1);
    clr = 1'b0; oneshot = 1'b1;
    step(9);
    chk_all("os_at_9", 9, 2, 1, 0);
    step(1);
    chk_all("os_done", 9, 3, 0, 1);
    step(5);
    chk_all("os_frozen", 9, 3, 0, 1);
    load_val = 8'd3; load = 1'b1;
    step(1);
    load = 1'b0;
    chk_all("os_load_exit", 3, 2, 0, 0);

    // 5. Load saturation and clr/load priority
    load_val = 8'd200; load = 1'b1;
    step(1);
    chk_all("load_sat", 9, 2, 0, 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0; load = 1'b0;
    chk_all("clr_over_load", 0, 1, 0, 0);
    up = 1'b0;
    #1 chk("tc_down_at_0", 32'(tc), 1);
    step(1);
    chk_all("down_os_done", 0, 3, 0, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk_all("clr_from_done", 0, 1, 0, 0);

    // 6. Reset mid-run
    up = 1'b1; oneshot = 1'b0;
    step(5);
    chk_all("run_to_5", 5, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_mid_run", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    step(1);
    chk_all("rst2_first_edge", 0, 1, 0, 0);
    step(1);
    chk_all("rst2_second_edge", 1, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
